// File: rtl/clock_divider_pkg.sv
// Shared types and constants for the clock divider controller and its
// divisor configuration slot.
package clock_divider_pkg;

    localparam int CNT_W_DEFAULT = 16;
    localparam int MIN_DIV       = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

endpackage

// File: rtl/clock_divider_cfg_slot.sv
// Divisor handshake slot: validates offered divisors, holds one pending value
// while the divider is running and strobes it out at a period boundary.
module clock_divider_cfg_slot
    import clock_divider_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic             active,
    input  logic             boundary,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             load,
    output logic [CNT_W-1:0] load_div
);

    logic             pending_valid_reg, pending_valid_next;
    logic [CNT_W-1:0] pending_div_reg, pending_div_next;
    logic             cfg_ready_reg;
    logic             cfg_err_reg;
    logic             accept;
    logic             div_ok;

    assign accept = cfg_valid && cfg_ready_reg;
    assign div_ok = (cfg_div >= CNT_W'(MIN_DIV));

    // A running divider never changes divisor mid-period, so accepted values
    // wait here; while idle there is no period to protect and they load at once.
    always_comb begin
        pending_valid_next = pending_valid_reg;
        pending_div_next   = pending_div_reg;
        load               = 1'b0;
        load_div           = cfg_div;
        if (boundary && pending_valid_reg) begin
            load               = 1'b1;
            load_div           = pending_div_reg;
            pending_valid_next = 1'b0;
        end
        if (accept && div_ok) begin
            if (active) begin
                pending_valid_next = 1'b1;
                pending_div_next   = cfg_div;
            end else begin
                load     = 1'b1;
                load_div = cfg_div;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            pending_valid_reg <= 1'b0;
            pending_div_reg   <= '0;
            cfg_ready_reg     <= 1'b1;
            cfg_err_reg       <= 1'b0;
        end else begin
            pending_valid_reg <= pending_valid_next;
            pending_div_reg   <= pending_div_next;
            cfg_ready_reg     <= !pending_valid_next;
            cfg_err_reg       <= accept && !div_ok;
        end
    end

    assign cfg_ready = cfg_ready_reg;
    assign cfg_err   = cfg_err_reg;

endmodule

// File: rtl/clock_divider_ctrl.sv
// Programmable clock divider: registered clk_out with period cur_div clk_in
// cycles, run/drain/idle control and boundary-synchronous divisor updates.
module clock_divider_ctrl
    import clock_divider_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int DIV_DEFAULT = 200
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clk_out,
    output logic             tick,
    output logic             busy,
    output logic [CNT_W-1:0] cur_div
);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] cur_div_reg;
    logic [CNT_W-1:0] half;
    logic             clk_out_reg, clk_out_next;
    logic             tick_reg, tick_next;
    logic             busy_reg, busy_next;
    logic             boundary;
    logic             load;
    logic [CNT_W-1:0] load_div;

    assign half     = cur_div_reg >> 1;
    assign boundary = (state_reg != ST_IDLE) && (cnt_reg == cur_div_reg - CNT_W'(1));

    clock_divider_cfg_slot #(
        .CNT_W (CNT_W)
    ) u_cfg_slot (
        .clk_in    (clk_in),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .active    (state_reg != ST_IDLE),
        .boundary  (boundary),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .load      (load),
        .load_div  (load_div)
    );

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        clk_out_next = clk_out_reg;
        tick_next    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                cnt_next     = '0;
                clk_out_next = 1'b0;
                if (en) begin
                    state_next   = ST_RUN;
                    clk_out_next = 1'b1;
                    tick_next    = 1'b1;
                end
            end
            ST_RUN, ST_DRAIN: begin
                if (boundary) begin
                    cnt_next = '0;
                    if (en) begin
                        state_next   = ST_RUN;
                        clk_out_next = 1'b1;
                        tick_next    = 1'b1;
                    end else begin
                        state_next   = ST_IDLE;
                        clk_out_next = 1'b0;
                    end
                end else begin
                    // Mid-period: phase lengths come only from the current divisor.
                    cnt_next     = cnt_reg + CNT_W'(1);
                    clk_out_next = (cnt_reg + CNT_W'(1)) < half;
                    state_next   = en ? ST_RUN : ST_DRAIN;
                end
            end
            default: begin
                state_next   = ST_IDLE;
                cnt_next     = '0;
                clk_out_next = 1'b0;
            end
        endcase
        busy_next = (state_next != ST_IDLE);
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            clk_out_reg <= 1'b0;
            tick_reg    <= 1'b0;
            busy_reg    <= 1'b0;
            cur_div_reg <= CNT_W'(DIV_DEFAULT);
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            clk_out_reg <= clk_out_next;
            tick_reg    <= tick_next;
            busy_reg    <= busy_next;
            if (load) begin
                cur_div_reg <= load_div;
            end
        end
    end

    assign clk_out = clk_out_reg;
    assign tick    = tick_reg;
    assign busy    = busy_reg;
    assign cur_div = cur_div_reg;

endmodule
